mem_port_arbiter: RTL

//  Two-requester arbiter/sequencer for the single shared 64-bit memory port.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mux2_1_64x.sv | 13 +
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Width of the access-latency down-counter (supports LAT up to 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mux2_1_64x.sv
// 64-bit 2:1 multiplexer unit.
// Latency: combinational.
// Backpressure: none.
module mux2_1_64x (
    input  logic        sel_i,
    input  logic [63:0] in0_i,
    input  logic [63:0] in1_i,
    output logic [63:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared 64-bit memory port (0 = fetch, 1 = data).
// Latency: grant registered 1 cycle after request; port held LAT cycles; done pulses the cycle after.
// Backpressure: requesters hold req until done; MEM_ARB_FIXED_PRIO_EN gives data port fixed tie priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] addr0,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [63:0]      mem_addr_q, mem_addr_d;
    logic [63:0]      mem_wdata_q, mem_wdata_d;
    logic [63:0]      rdata_q, rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic             last_q, last_d;
    logic             tie;
`endif

    logic             any_req;
    logic             win_sel;
    logic             win_we;
    logic             rd_cap;
    logic [63:0]      win_addr;
    logic [63:0]      win_wdata;
    logic [63:0]      rdata_nxt;

    // Choose the winner among current requests; a lone request always wins.
    always_comb begin
        any_req = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Data port takes every tie; fetch may starve under sustained data traffic.
        win_sel = req1;
`else
        // On a tie the port that did not win the previous tie goes next.
        tie     = req0 & req1;
        win_sel = tie ? ~last_q : req1;
`endif
    end

    assign win_we = win_sel ? we1 : we0;

    // Read data is taken on the final BUSY cycle of a read; writes leave rdata untouched.
    assign rd_cap = (state_q == BUSY) && (cnt_q == '0) && !mem_we_q;

    mux2_1_64x u_addr_mux (
        .sel_i (win_sel),
        .in0_i (addr0),
        .in1_i (addr1),
        .out_o (win_addr)
    );

    mux2_1_64x u_wdata_mux (
        .sel_i (win_sel),
        .in0_i (wdata0),
        .in1_i (wdata1),
        .out_o (win_wdata)
    );

    mux2_1_64x u_rdata_mux (
        .sel_i (rd_cap),
        .in0_i (rdata_q),
        .in1_i (mem_rdata),
        .out_o (rdata_nxt)
    );

    // Next-state and registered-output computation for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_nxt;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // Arbitrating in DONE lets a new access start right after the done pulse.
                if (any_req) begin
                    state_d     = BUSY;
                    cnt_d       = CNT_INIT;
                    sel_d       = win_sel;
                    gnt0_d      = ~win_sel;
                    gnt1_d      = win_sel;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win_we;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    if (tie) begin
                        last_d = win_sel;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                gnt0_d = ~sel_q;
                gnt1_d = sel_q;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
